uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 36 +++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and pointer-width helper for the UART RX/TX buffering blocks.
package uart_rx_fifo_pkg;

    localparam int DATA_WD_DEF = 8;
    localparam int DEPTH_DEF   = 16;
    localparam int CNT_WD_DEF  = 8;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_wd(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array: synchronous write, registered read that holds its value when idle.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int data_wd = DATA_WD_DEF,
    parameter int depth   = DEPTH_DEF,
    localparam int aw     = $clog2(depth)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [aw-1:0]      wr_addr,
    input  logic [data_wd-1:0] wr_data,
    input  logic               rd_en,
    input  logic [aw-1:0]      rd_addr,
    output logic [data_wd-1:0] rd_data
);

    logic [data_wd-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address write and read return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side frame FIFO with sticky overflow flag and saturating parity/framing error counters.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int data_wd = DATA_WD_DEF,
    parameter int depth   = DEPTH_DEF,
    parameter int cnt_wd  = CNT_WD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_done,
    input  logic [data_wd-1:0]       rx_data,
    input  logic                     parity_error_flag,
    input  logic                     framing_error_flag,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [data_wd-1:0]       dout,
    output logic                     dout_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow,
    output logic [cnt_wd-1:0]        parity_err_cnt,
    output logic [cnt_wd-1:0]        framing_err_cnt
);

    localparam int aw = $clog2(depth);
    localparam int pw = ptr_wd(depth);

    logic [pw-1:0]     wr_ptr_reg;
    logic [pw-1:0]     rd_ptr_reg;
    logic              rx_done_d_reg;
    logic              parity_d_reg;
    logic              framing_d_reg;
    logic              dout_valid_reg;
    logic              overflow_reg;
    logic [cnt_wd-1:0] parity_cnt_reg;
    logic [cnt_wd-1:0] framing_cnt_reg;

    logic wr_evt;
    logic rd_ok;
    logic wr_ok;
    logic drop;
    logic parity_evt;
    logic framing_evt;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[aw-1:0] == rd_ptr_reg[aw-1:0]) &&
                   (wr_ptr_reg[aw] != rd_ptr_reg[aw]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign wr_evt      = rx_done & ~rx_done_d_reg;
    assign parity_evt  = parity_error_flag & ~parity_d_reg;
    assign framing_evt = framing_error_flag & ~framing_d_reg;
    assign rd_ok       = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign wr_ok       = wr_evt & (~full | rd_ok);
    assign drop        = wr_evt & full & ~rd_ok;

    uart_fifo_mem #(
        .data_wd (data_wd),
        .depth   (depth)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_reg[aw-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_reg[aw-1:0]),
        .rd_data (dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            rx_done_d_reg  <= 1'b0;
            parity_d_reg   <= 1'b0;
            framing_d_reg  <= 1'b0;
            dout_valid_reg <= 1'b0;
        end else begin
            rx_done_d_reg  <= rx_done;
            parity_d_reg   <= parity_error_flag;
            framing_d_reg  <= framing_error_flag;
            dout_valid_reg <= rd_ok;
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // err_clr takes priority over any coincident error event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg    <= 1'b0;
            parity_cnt_reg  <= '0;
            framing_cnt_reg <= '0;
        end else if (err_clr) begin
            overflow_reg    <= 1'b0;
            parity_cnt_reg  <= '0;
            framing_cnt_reg <= '0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (parity_evt && (parity_cnt_reg != '1)) begin
                parity_cnt_reg <= parity_cnt_reg + 1'b1;
            end
            if (framing_evt && (framing_cnt_reg != '1)) begin
                framing_cnt_reg <= framing_cnt_reg + 1'b1;
            end
        end
    end

    assign dout_valid      = dout_valid_reg;
    assign overflow        = overflow_reg;
    assign parity_err_cnt  = parity_cnt_reg;
    assign framing_err_cnt = framing_cnt_reg;

endmodule
